// File: rtl/ahb_arbiter_2m.sv
// Two-master bus arbiter: M0 (fetch) and M1 (data) share one command bus.
// A grant latches the winner's command, then one ADDR cycle and a DATA phase that HREADY can stretch.
module ahb_arbiter_2m #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WEB_W      = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_m0,
  input  logic [DATA_W-1:0] wdata_m0,
  input  logic              read_m0,
  input  logic [WEB_W-1:0]  write_m0,
  output logic [DATA_W-1:0] rdata_m0,
  output logic              stall_m0,
  input  logic [ADDR_W-1:0] addr_m1,
  input  logic [DATA_W-1:0] wdata_m1,
  input  logic              read_m1,
  input  logic [WEB_W-1:0]  write_m1,
  output logic [DATA_W-1:0] rdata_m1,
  output logic              stall_m1,
  output logic [ADDR_W-1:0] HADDR,
  output logic              HREAD,
  output logic [WEB_W-1:0]  HWRITE,
  output logic [DATA_W-1:0] HWDATA,
  input  logic [DATA_W-1:0] HRDATA,
  input  logic              HREADY
);

  // state  | meaning
  // S_IDLE | no transaction; grant on any request
  // S_ADDR | latched command on the bus for one cycle
  // S_DATA | wait for HREADY, then complete
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_owner;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_haddr;
  logic              r_read;
  logic [WEB_W-1:0]  r_write;
  logic [DATA_W-1:0] r_hwdata;

  logic w_req0, w_req1, w_grant, w_winner, w_done;

  assign w_req0  = read_m0 | (write_m0 != '1);
  assign w_req1  = read_m1 | (write_m1 != '1);
  assign w_grant = (r_state == S_IDLE) && (w_req0 || w_req1);
  assign w_done  = (r_state == S_DATA) && HREADY;

  always_comb begin
    w_winner = 1'b0;
    if (w_req0 && w_req1)
      w_winner = (FIXED_PRIO != 0) ? 1'b0 : ~r_last_grant;
    else if (w_req1)
      w_winner = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_grant) w_state_nxt = S_ADDR;
      S_ADDR:  w_state_nxt = S_DATA;
      S_DATA:  if (HREADY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_haddr      <= '0;
      r_read       <= 1'b0;
      r_write      <= '1;
      r_hwdata     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_owner      <= w_winner;
        r_last_grant <= w_winner;
        // a write from the same master suppresses its read strobe
        if (w_winner) begin
          r_haddr  <= addr_m1;
          r_write  <= write_m1;
          r_read   <= read_m1 && (write_m1 == '1);
          r_hwdata <= wdata_m1;
        end else begin
          r_haddr  <= addr_m0;
          r_write  <= write_m0;
          r_read   <= read_m0 && (write_m0 == '1);
          r_hwdata <= wdata_m0;
        end
      end
    end
  end

  assign HADDR  = r_haddr;
  assign HWDATA = r_hwdata;
  assign HREAD  = (r_state == S_ADDR) && r_read;
  assign HWRITE = (r_state == S_ADDR) ? r_write : '1;

  assign rdata_m0 = (w_done && !r_owner) ? HRDATA : '0;
  assign rdata_m1 = (w_done &&  r_owner) ? HRDATA : '0;
  assign stall_m0 = w_req0 && !(w_done && !r_owner);
  assign stall_m1 = w_req1 && !(w_done &&  r_owner);

endmodule

// File: tb/tb_ahb_arbiter_2m.sv
// Directed, table-driven bench: one row per clock cycle, both priority modes instantiated side by side.
module tb_ahb_arbiter_2m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] addr_m0, wdata_m0, addr_m1, wdata_m1, hrdata;
  logic        read_m0, read_m1, hready;
  logic [3:0]  write_m0, write_m1;

  logic [31:0] rdata_m0_o [2];
  logic [31:0] rdata_m1_o [2];
  logic        stall_m0_o [2];
  logic        stall_m1_o [2];
  logic [31:0] haddr_o    [2];
  logic        hread_o    [2];
  logic [3:0]  hwrite_o   [2];
  logic [31:0] hwdata_o   [2];

  ahb_arbiter_2m #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .rst(rst),
    .addr_m0(addr_m0), .wdata_m0(wdata_m0), .read_m0(read_m0), .write_m0(write_m0),
    .rdata_m0(rdata_m0_o[0]), .stall_m0(stall_m0_o[0]),
    .addr_m1(addr_m1), .wdata_m1(wdata_m1), .read_m1(read_m1), .write_m1(write_m1),
    .rdata_m1(rdata_m1_o[0]), .stall_m1(stall_m1_o[0]),
    .HADDR(haddr_o[0]), .HREAD(hread_o[0]), .HWRITE(hwrite_o[0]), .HWDATA(hwdata_o[0]),
    .HRDATA(hrdata), .HREADY(hready)
  );

  ahb_arbiter_2m #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .rst(rst),
    .addr_m0(addr_m0), .wdata_m0(wdata_m0), .read_m0(read_m0), .write_m0(write_m0),
    .rdata_m0(rdata_m0_o[1]), .stall_m0(stall_m0_o[1]),
    .addr_m1(addr_m1), .wdata_m1(wdata_m1), .read_m1(read_m1), .write_m1(write_m1),
    .rdata_m1(rdata_m1_o[1]), .stall_m1(stall_m1_o[1]),
    .HADDR(haddr_o[1]), .HREAD(hread_o[1]), .HWRITE(hwrite_o[1]), .HWDATA(hwdata_o[1]),
    .HRDATA(hrdata), .HREADY(hready)
  );

  typedef struct {
    bit          sel;
    bit          chk;
    logic        rst;
    logic        rd0;
    logic [3:0]  wr0;
    logic [31:0] a0;
    logic [31:0] wd0;
    logic        rd1;
    logic [3:0]  wr1;
    logic [31:0] a1;
    logic [31:0] wd1;
    logic        rdy;
    logic [31:0] hr;
    logic [31:0] eha;
    logic        ehr;
    logic [3:0]  ehw;
    logic [31:0] ehd;
    logic [31:0] er0;
    logic [31:0] er1;
    logic        es0;
    logic        es1;
  } vec_t;

  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [31:0] F = 32'hF;
  localparam logic [31:0] W = 32'h1234_5678;

  function automatic void t(input int sel, input int chk, input int r,
                            input int rd0, input logic [31:0] wr0, input logic [31:0] a0, input logic [31:0] wd0,
                            input int rd1, input logic [31:0] wr1, input logic [31:0] a1, input logic [31:0] wd1,
                            input int rdy, input logic [31:0] hr,
                            input logic [31:0] eha, input int ehr, input logic [31:0] ehw, input logic [31:0] ehd,
                            input logic [31:0] er0, input logic [31:0] er1, input int es0, input int es1);
    vec_t v;
    v.sel = (sel != 0); v.chk = (chk != 0); v.rst = (r != 0);
    v.rd0 = (rd0 != 0); v.wr0 = wr0[3:0]; v.a0 = a0; v.wd0 = wd0;
    v.rd1 = (rd1 != 0); v.wr1 = wr1[3:0]; v.a1 = a1; v.wd1 = wd1;
    v.rdy = (rdy != 0); v.hr = hr;
    v.eha = eha; v.ehr = (ehr != 0); v.ehw = ehw[3:0]; v.ehd = ehd;
    v.er0 = er0; v.er1 = er1; v.es0 = (es0 != 0); v.es1 = (es1 != 0);
    tbl.push_back(v);
  endfunction

  function automatic void rst_row();
    t(0,0,1, 0,F,0,0, 0,F,0,0, 1,0, 0,0,F,0, 0,0,0,0);
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d got=%h want=%h", nm, row, act, exp);
    end
  endtask

  task automatic check_row(input int i, input vec_t v);
    int s;
    s = v.sel ? 1 : 0;
    chk("HADDR",    i, haddr_o[s],            v.eha);
    chk("HREAD",    i, {31'd0, hread_o[s]},   {31'd0, v.ehr});
    chk("HWRITE",   i, {28'd0, hwrite_o[s]},  {28'd0, v.ehw});
    chk("HWDATA",   i, hwdata_o[s],           v.ehd);
    chk("rdata_m0", i, rdata_m0_o[s],         v.er0);
    chk("rdata_m1", i, rdata_m1_o[s],         v.er1);
    chk("stall_m0", i, {31'd0, stall_m0_o[s]}, {31'd0, v.es0});
    chk("stall_m1", i, {31'd0, stall_m1_o[s]}, {31'd0, v.es1});
  endtask

  int  gk;
  bit  found;

  initial begin
    rst = 1'b1; read_m0 = 1'b0; read_m1 = 1'b0; write_m0 = 4'hF; write_m1 = 4'hF;
    addr_m0 = '0; addr_m1 = '0; wdata_m0 = '0; wdata_m1 = '0; hready = 1'b1; hrdata = '0;

    // reset values, both instances
    rst_row();
    t(0,1,0, 0,F,0,0, 0,F,0,0, 1,32'hDEAD, 0,0,F,0, 0,0,0,0);
    t(1,1,0, 0,F,0,0, 0,F,0,0, 1,32'hDEAD, 0,0,F,0, 0,0,0,0);
    // lone M0 read
    t(0,1,0, 1,F,'h100,0, 0,F,0,0, 1,32'hCAFE0001, 0,0,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h100,0, 0,F,0,0, 1,32'hCAFE0001, 'h100,1,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h100,0, 0,F,0,0, 1,32'hCAFE0001, 'h100,0,F,0, 32'hCAFE0001,0,0,0);
    t(0,1,0, 0,F,'h100,0, 0,F,0,0, 1,32'hCAFE0001, 'h100,0,F,0, 0,0,0,0);
    // contention, round robin
    rst_row();
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h11, 0,0,F,0,      0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h11, 'h100,1,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h11, 'h100,0,F,0,  'h11,0,0,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h22, 'h100,0,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h22, 'h200,1,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h22, 'h200,0,F,0,  0,'h22,1,0);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h33, 'h200,0,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h33, 'h100,1,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h33, 'h100,0,F,0,  'h33,0,0,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h44, 'h100,0,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h44, 'h200,1,F,0,  0,0,1,1);
    t(0,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h44, 'h200,0,F,0,  0,'h44,1,0);
    // contention, fixed priority
    rst_row();
    t(1,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h55, 0,0,F,0,      0,0,1,1);
    t(1,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h55, 'h100,1,F,0,  0,0,1,1);
    t(1,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h55, 'h100,0,F,0,  'h55,0,0,1);
    t(1,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h66, 'h100,0,F,0,  0,0,1,1);
    t(1,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h66, 'h100,1,F,0,  0,0,1,1);
    t(1,1,0, 1,F,'h100,0, 1,F,'h200,0, 1,'h66, 'h100,0,F,0,  'h66,0,0,1);
    t(1,1,0, 0,F,'h100,0, 1,F,'h200,0, 1,'h77, 'h100,0,F,0,  0,0,0,1);
    t(1,1,0, 0,F,'h100,0, 1,F,'h200,0, 1,'h77, 'h200,1,F,0,  0,0,0,1);
    t(1,1,0, 0,F,'h100,0, 1,F,'h200,0, 1,'h77, 'h200,0,F,0,  0,'h77,0,0);
    t(1,1,0, 0,F,'h100,0, 0,F,'h200,0, 1,'h77, 'h200,0,F,0,  0,0,0,0);
    // M1 write with read also set (write wins), two wait states
    rst_row();
    t(0,1,0, 0,F,0,0, 1,'hC,'h200,W, 1,'hAB, 0,0,F,0,       0,0,0,1);
    t(0,1,0, 0,F,0,0, 1,'hC,'h200,W, 1,'hAB, 'h200,0,'hC,W, 0,0,0,1);
    t(0,1,0, 0,F,0,0, 1,'hC,'h200,W, 0,'hAB, 'h200,0,F,W,   0,0,0,1);
    t(0,1,0, 0,F,0,0, 1,'hC,'h200,W, 0,'hAB, 'h200,0,F,W,   0,0,0,1);
    t(0,1,0, 0,F,0,0, 1,'hC,'h200,W, 1,'hAB, 'h200,0,F,W,   0,'hAB,0,0);
    t(0,1,0, 0,F,0,0, 0,F,'h200,W,   1,'hAB, 'h200,0,F,W,   0,0,0,0);
    // reset during a stretched DATA phase, then re-grant
    t(0,1,0, 1,F,'h300,0, 0,F,'h200,W, 1,'h99, 'h200,0,F,W, 0,0,1,0);
    t(0,1,0, 1,F,'h300,0, 0,F,'h200,W, 1,'h99, 'h300,1,F,0, 0,0,1,0);
    t(0,1,1, 1,F,'h300,0, 0,F,'h200,W, 0,'h99, 'h300,0,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h300,0, 0,F,'h200,W, 1,'h99, 0,0,F,0,     0,0,1,0);
    t(0,1,0, 1,F,'h300,0, 0,F,'h200,W, 1,'h99, 'h300,1,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h300,0, 0,F,'h200,W, 1,'h99, 'h300,0,F,0, 'h99,0,0,0);
    t(0,1,0, 0,F,'h300,0, 0,F,'h200,W, 1,'h99, 'h300,0,F,0, 0,0,0,0);
    // master address changes after grant
    t(0,1,0, 1,F,'h400,0, 0,F,0,0, 1,'hBEEF, 'h300,0,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h500,0, 0,F,0,0, 1,'hBEEF, 'h400,1,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h500,0, 0,F,0,0, 0,'hBEEF, 'h400,0,F,0, 0,0,1,0);
    t(0,1,0, 1,F,'h500,0, 0,F,0,0, 1,'hBEEF, 'h400,0,F,0, 'hBEEF,0,0,0);
    t(0,1,0, 0,F,'h500,0, 0,F,0,0, 1,'hBEEF, 'h400,0,F,0, 0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      rst = tbl[i].rst;
      read_m0 = tbl[i].rd0; write_m0 = tbl[i].wr0; addr_m0 = tbl[i].a0; wdata_m0 = tbl[i].wd0;
      read_m1 = tbl[i].rd1; write_m1 = tbl[i].wr1; addr_m1 = tbl[i].a1; wdata_m1 = tbl[i].wd1;
      hready = tbl[i].rdy; hrdata = tbl[i].hr;
      @(negedge clk);
      if (tbl[i].chk) check_row(i, tbl[i]);
    end

    // long wait-state write from M1: find the ADDR cycle within a bounded window
    @(posedge clk); #1;
    rst = 1'b0; read_m0 = 1'b0; write_m0 = 4'hF; read_m1 = 1'b0;
    write_m1 = 4'h0; addr_m1 = 32'h600; wdata_m1 = 32'hA5A5_A5A5; hready = 1'b0;
    found = 1'b0;
    gk = 0;
    while (!found && gk < 10) begin
      @(negedge clk);
      if (hwrite_o[0] == 4'h0) found = 1'b1;
      else begin
        gk++;
        @(posedge clk); #1;
      end
    end
    chk("grant_seen", 100, {31'd0, found}, 32'd1);
    chk("grant_lat",  101, gk, 32'd1);
    chk("addr_w",     102, haddr_o[0], 32'h600);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("wait_stall",  110 + k, {31'd0, stall_m1_o[0]}, 32'd1);
      chk("wait_hwrite", 110 + k, {28'd0, hwrite_o[0]},   32'hF);
      chk("wait_hwdata", 110 + k, hwdata_o[0],            32'hA5A5_A5A5);
    end
    @(posedge clk); #1;
    hready = 1'b1; hrdata = 32'h5A;
    @(negedge clk);
    chk("done_stall", 120, {31'd0, stall_m1_o[0]}, 32'd0);
    chk("done_rdata", 121, rdata_m1_o[0], 32'h5A);
    @(posedge clk); #1;
    write_m1 = 4'hF;
    @(negedge clk);
    chk("idle_hwrite", 122, {28'd0, hwrite_o[0]}, 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
